// File: rtl/cascade_in.sv
// rtl/cascade_in.sv - DSP slice cascade input stage: Z-mux PCIN operands and ALU carry-in select
module cascade_in (
    input  logic               clk,
    input  logic               rst,
    input  logic               CECARRYIN,
    input  logic               CECTRL,
    input  logic               CEM,
    input  logic               CARRYINREG,
    input  logic               CARRYINSELREG,
    input  logic               MREG,
    input  logic               CARRYIN,
    input  logic [2:0]         CARRYINSEL,
    input  logic               CARRYCASCIN,
    input  logic signed [47:0] PCIN,
    input  logic signed [47:0] P,
    input  logic               CARRYCASCOUT,
    input  logic               A24,
    input  logic               B17,
    output logic signed [47:0] PCIN_Z,
    output logic signed [47:0] PCIN_SHR17,
    output logic               CIN,
    output logic [2:0]         CARRYINSEL_Q
);

    logic       r_carryin;
    logic [2:0] r_sel;
    logic       r_rnd;

    logic       w_carryin_q;
    logic [2:0] w_sel_q;
    logic       w_rnd_d;
    logic       w_rnd_q;

    // Rounding term for the multiplier: set when the A and B operand signs agree
    assign w_rnd_d = ~(A24 ^ B17);

    // Optional pipeline registers; each loads under its own enable and clears asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_carryin <= 1'b0;
            r_sel     <= 3'b000;
            r_rnd     <= 1'b0;
        end else begin
            if (CECARRYIN) r_carryin <= CARRYIN;
            if (CECTRL)    r_sel     <= CARRYINSEL;
            if (CEM)       r_rnd     <= w_rnd_d;
        end
    end

    // Static register-use pins choose stored value or live input; bypass paths ignore rst
    assign w_carryin_q  = CARRYINREG    ? r_carryin : CARRYIN;
    assign w_sel_q      = CARRYINSELREG ? r_sel     : CARRYINSEL;
    assign w_rnd_q      = MREG          ? r_rnd     : w_rnd_d;
    assign CARRYINSEL_Q = w_sel_q;

    // Cascade operands are never registered here; upstream owns their timing
    assign PCIN_Z     = PCIN;
    assign PCIN_SHR17 = {{17{PCIN[47]}}, PCIN[47:17]};

    // Carry-in source decode; feedback sources (P, PCIN, cascades) are always live
    always_comb begin
        CIN = 1'b0;
        case (w_sel_q)
            3'b000: CIN = w_carryin_q;
            3'b001: CIN = ~PCIN[47];
            3'b010: CIN = CARRYCASCIN;
            3'b011: CIN = PCIN[47];
            3'b100: CIN = CARRYCASCOUT;
            3'b101: CIN = ~P[47];
            3'b110: CIN = w_rnd_q;
            3'b111: CIN = P[47];
            default: CIN = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_cascade_in.sv
// tb/tb_cascade_in.sv - directed self-checking bench for cascade_in
`timescale 1ns/1ps
module tb_cascade_in;

    logic               clk;
    logic               rst;
    logic               CECARRYIN, CECTRL, CEM;
    logic               CARRYINREG, CARRYINSELREG, MREG;
    logic               CARRYIN;
    logic [2:0]         CARRYINSEL;
    logic               CARRYCASCIN;
    logic signed [47:0] PCIN;
    logic signed [47:0] P;
    logic               CARRYCASCOUT;
    logic               A24, B17;
    logic signed [47:0] PCIN_Z;
    logic signed [47:0] PCIN_SHR17;
    logic               CIN;
    logic [2:0]         CARRYINSEL_Q;

    int checks = 0;
    int errors = 0;

    cascade_in dut (
        .clk(clk), .rst(rst),
        .CECARRYIN(CECARRYIN), .CECTRL(CECTRL), .CEM(CEM),
        .CARRYINREG(CARRYINREG), .CARRYINSELREG(CARRYINSELREG), .MREG(MREG),
        .CARRYIN(CARRYIN), .CARRYINSEL(CARRYINSEL), .CARRYCASCIN(CARRYCASCIN),
        .PCIN(PCIN), .P(P), .CARRYCASCOUT(CARRYCASCOUT),
        .A24(A24), .B17(B17),
        .PCIN_Z(PCIN_Z), .PCIN_SHR17(PCIN_SHR17),
        .CIN(CIN), .CARRYINSEL_Q(CARRYINSEL_Q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        CARRYINREG = 1'b1; CARRYINSELREG = 1'b1; MREG = 1'b1;
        CECARRYIN = 1'b1; CECTRL = 1'b1; CEM = 1'b1;
        CARRYIN = 1'b1; CARRYINSEL = 3'b000;
        tick(); tick();
        checks++;
        if (CARRYINSEL_Q !== 3'b000) begin errors++; $display("FAIL reset_sel got=%b exp=000", CARRYINSEL_Q); end
        checks++;
        if (CIN !== 1'b0) begin errors++; $display("FAIL reset_cin got=%b exp=0", CIN); end
        rst = 1'b0;
        tick(); tick();
        checks++;
        if (CIN !== 1'b1) begin errors++; $display("FAIL reset_run_cin got=%b exp=1", CIN); end
        #3 rst = 1'b1;
        #1;
        checks++;
        if (CIN !== 1'b0) begin errors++; $display("FAIL reset_async_cin got=%b exp=0", CIN); end
        checks++;
        if (CARRYINSEL_Q !== 3'b000) begin errors++; $display("FAIL reset_async_sel got=%b exp=000", CARRYINSEL_Q); end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_latency();
        CARRYINSELREG = 1'b0; CARRYINSEL = 3'b000;
        CARRYINREG = 1'b1; CECARRYIN = 1'b1; CARRYIN = 1'b0;
        tick(); tick();
        CARRYIN = 1'b1;
        #1;
        checks++;
        if (CIN !== 1'b0) begin errors++; $display("FAIL latency_before_edge got=%b exp=0", CIN); end
        tick();
        checks++;
        if (CIN !== 1'b1) begin errors++; $display("FAIL latency_after_edge got=%b exp=1", CIN); end
        CARRYINREG = 1'b0; CARRYIN = 1'b0;
        #1;
        checks++;
        if (CIN !== 1'b0) begin errors++; $display("FAIL bypass_low got=%b exp=0", CIN); end
        CARRYIN = 1'b1;
        #1;
        checks++;
        if (CIN !== 1'b1) begin errors++; $display("FAIL bypass_high got=%b exp=1", CIN); end
    endtask

    task automatic test_select_sweep();
        logic [7:0] exp_v;
        exp_v = 8'b0110_1100;
        CARRYINSELREG = 1'b0; CARRYINREG = 1'b0; CARRYIN = 1'b0;
        MREG = 1'b0; A24 = 1'b1; B17 = 1'b1;
        PCIN = 48'sh8000_0000_0000; P = 48'sh0000_0000_0000;
        CARRYCASCIN = 1'b1; CARRYCASCOUT = 1'b0;
        for (int s = 0; s < 8; s++) begin
            CARRYINSEL = 3'(s);
            #1;
            checks++;
            if (CIN !== exp_v[s]) begin errors++; $display("FAIL sweep_sel%0d got=%b exp=%b", s, CIN, exp_v[s]); end
        end
    endtask

    task automatic test_shift();
        PCIN = 48'sh8000_0002_0000;
        #1;
        checks++;
        if (PCIN_SHR17 !== 48'shFFFF_C000_0001) begin errors++; $display("FAIL shift_neg got=%h exp=ffffc0000001", PCIN_SHR17); end
        checks++;
        if (PCIN_Z !== 48'sh8000_0002_0000) begin errors++; $display("FAIL pcin_z got=%h exp=800000020000", PCIN_Z); end
        PCIN = 48'sh0000_0002_0000;
        #1;
        checks++;
        if (PCIN_SHR17 !== 48'sh0000_0000_0001) begin errors++; $display("FAIL shift_pos got=%h exp=000000000001", PCIN_SHR17); end
    endtask

    task automatic test_ce_hold();
        CARRYINSELREG = 1'b0; CARRYINSEL = 3'b110;
        MREG = 1'b1; CEM = 1'b1; A24 = 1'b0; B17 = 1'b0;
        tick();
        checks++;
        if (CIN !== 1'b1) begin errors++; $display("FAIL ce_load got=%b exp=1", CIN); end
        CEM = 1'b0; A24 = 1'b1;
        tick();
        checks++;
        if (CIN !== 1'b1) begin errors++; $display("FAIL ce_hold got=%b exp=1", CIN); end
        CARRYINSEL = 3'b111; P = 48'sh8000_0000_0000;
        #1;
        checks++;
        if (CIN !== 1'b1) begin errors++; $display("FAIL ce_live_p got=%b exp=1", CIN); end
        CARRYINSEL = 3'b110; MREG = 1'b0;
        #1;
        checks++;
        if (CIN !== 1'b0) begin errors++; $display("FAIL rnd_bypass got=%b exp=0", CIN); end
    endtask

    task automatic test_mixed();
        CARRYINREG = 1'b0; CARRYIN = 1'b0; CARRYCASCIN = 1'b1;
        CARRYINSELREG = 1'b1; CECTRL = 1'b1; CARRYINSEL = 3'b000;
        tick(); tick(); tick(); tick();
        CARRYINSEL = 3'b010;
        #1;
        checks++;
        if (CIN !== 1'b0) begin errors++; $display("FAIL mixed_before got=%b exp=0", CIN); end
        checks++;
        if (CARRYINSEL_Q !== 3'b000) begin errors++; $display("FAIL mixed_sel_before got=%b exp=000", CARRYINSEL_Q); end
        tick();
        checks++;
        if (CIN !== 1'b1) begin errors++; $display("FAIL mixed_after got=%b exp=1", CIN); end
        checks++;
        if (CARRYINSEL_Q !== 3'b010) begin errors++; $display("FAIL mixed_sel_after got=%b exp=010", CARRYINSEL_Q); end
    endtask

    task automatic test_back_to_back();
        // select and source change together, both registered
        CARRYINREG = 1'b1; CECARRYIN = 1'b1; CARRYIN = 1'b1;
        CARRYINSEL = 3'b010; CARRYCASCIN = 1'b0;
        tick();
        CARRYINSEL = 3'b000; CARRYIN = 1'b0;
        #1;
        checks++;
        if (CIN !== 1'b0) begin errors++; $display("FAIL b2b_before got=%b exp=0", CIN); end
        CARRYIN = 1'b1;
        tick();
        checks++;
        if (CIN !== 1'b1) begin errors++; $display("FAIL b2b_after got=%b exp=1", CIN); end
        CECTRL = 1'b0; CECARRYIN = 1'b0; CARRYIN = 1'b0; CARRYINSEL = 3'b011;
        tick(); tick();
        checks++;
        if (CIN !== 1'b1) begin errors++; $display("FAIL hold_ctrl got=%b exp=1", CIN); end
    endtask

    task automatic test_rst_wins();
        CARRYINSEL = 3'b000; CECTRL = 1'b1;
        CECARRYIN = 1'b1; CARRYIN = 1'b1;
        rst = 1'b1;
        tick();
        checks++;
        if (CIN !== 1'b0) begin errors++; $display("FAIL rst_wins got=%b exp=0", CIN); end
        CECARRYIN = 1'b0;
        #1 rst = 1'b0;
        tick();
        checks++;
        if (CIN !== 1'b0) begin errors++; $display("FAIL post_rst_ce0 got=%b exp=0", CIN); end
        CECARRYIN = 1'b1;
        tick();
        checks++;
        if (CIN !== 1'b1) begin errors++; $display("FAIL post_rst_ce1 got=%b exp=1", CIN); end
    endtask

    initial begin
        rst = 1'b1;
        CECARRYIN = 1'b0; CECTRL = 1'b0; CEM = 1'b0;
        CARRYINREG = 1'b0; CARRYINSELREG = 1'b0; MREG = 1'b0;
        CARRYIN = 1'b0; CARRYINSEL = 3'b000; CARRYCASCIN = 1'b0;
        PCIN = '0; P = '0; CARRYCASCOUT = 1'b0; A24 = 1'b0; B17 = 1'b0;
        #2;
        test_reset();
        test_latency();
        test_select_sweep();
        test_shift();
        test_ce_hold();
        test_mixed();
        test_back_to_back();
        test_rst_wins();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cascade_in.md
# cascade_in

Input side of the DSP48E1 cascade and carry path. It is the counterpart of the slice output stage that drives P, PCOUT, CARRYOUT and CARRYCASCOUT. It accepts PCIN and CARRYCASCIN from the upstream slice and feeds back this slice's own P and CARRYCASCOUT. It produces the Z-mux cascade operands (PCIN and PCIN>>>17) and the single ALU carry-in selected by CARRYINSEL, with optional registers on CARRYIN, CARRYINSEL and the multiplier rounding term.

## Interface
Parameters:
- none. Register use is selected by static input pins, the same way the slice selects its other registers.

Ports:
- clk  in  1  slice clock; all registers update on the rising edge.
- rst  in  1  asynchronous, active-high reset; clears every internal register to 0.
- CECARRYIN  in  1  clock enable for the CARRYIN register.
- CECTRL  in  1  clock enable for the CARRYINSEL register.
- CEM  in  1  clock enable for the rounding-term register (shared with the M stage).
- CARRYINREG  in  1  static; 1 = CARRYIN registered, 0 = bypass.
- CARRYINSELREG  in  1  static; 1 = CARRYINSEL registered, 0 = bypass.
- MREG  in  1  static; 1 = rounding term registered, 0 = bypass.
- CARRYIN  in  1  fabric carry input.
- CARRYINSEL  in  3  carry source select.
- CARRYCASCIN  in  1  carry from the upstream slice's CARRYCASCOUT.
- PCIN  in  48 signed  upstream slice PCOUT.
- P  in  48 signed  this slice's registered P, fed back.
- CARRYCASCOUT  in  1  this slice's CARRYCASCOUT, fed back.
- A24  in  1  A[24], sign bit of the multiplier A operand.
- B17  in  1  B[17], sign bit of the multiplier B operand.
- PCIN_Z  out  48 signed  PCIN passed through, for Z-mux select 001.
- PCIN_SHR17  out  48 signed  PCIN arithmetic-shifted right 17 bits, for Z-mux select 101.
- CIN  out  1  selected ALU carry-in.
- CARRYINSEL_Q  out  3  effective (registered or bypassed) select, for downstream use.

## Operation
- Each optional register follows the same rules:
  - REG=1: loads D on clk when its CE=1, holds otherwise.
  - REG=1: async-cleared to 0 by rst.
  - REG=0: output equals live D combinationally; the register still clocks but is unused.
- Registered terms:
  - carryin_q: CARRYIN, gated by CECARRYIN and CARRYINREG.
  - sel_q (= CARRYINSEL_Q): CARRYINSEL, gated by CECTRL and CARRYINSELREG.
  - rnd_q: stores the value ~(A24 ^ B17), gated by CEM and MREG.
- CIN decode on sel_q:
  - 000 → carryin_q
  - 001 → ~PCIN[47]
  - 010 → CARRYCASCIN
  - 011 → PCIN[47]
  - 100 → CARRYCASCOUT
  - 101 → ~P[47]
  - 110 → rnd_q
  - 111 → P[47]
- PCIN, P, CARRYCASCIN and CARRYCASCOUT are never registered here. Their registration lives upstream or in the output stage.
- PCIN_Z = PCIN.
- PCIN_SHR17 = {{17{PCIN[47]}}, PCIN[47:17]}: 48-bit sign-preserving shift; bits [47:30] all equal PCIN[47].
- Reset values:
  - Registered outputs: CARRYINSEL_Q = 0, so CIN = carryin_q = 0 when CARRYINSELREG=1.
  - Bypassed outputs follow their inputs even during rst.
  - PCIN_Z and PCIN_SHR17 are combinational and follow PCIN even during rst.

## Timing
- Bypass path (REG=0): zero-cycle, combinational from pin to CIN.
- Registered path (REG=1): one cycle. A value present before edge N appears on CIN after edge N, provided its CE was 1 at edge N.
- Simultaneous change of select and source, both registered: CIN after edge N reflects the new select applied to the new source.
- Mixed register settings: each path keeps its own latency. Example: CARRYINSELREG=1, CARRYINREG=0 means the select lags one cycle but carryin_q is live.
- CE low holds the stored value indefinitely; CIN still tracks live feedback sources such as P and PCIN.
- rst asserted mid-operation:
  - Registers clear immediately, without waiting for clk.
  - On the first edge after rst deasserts, registers load only if their CE=1.
- rst together with CE=1: rst wins.
- Changing a static REG pin while running is allowed. The effect is immediate selection between the stored value and the live input; no glitch-free guarantee.

## Test plan
- Reset:
  - Stimulus: all REG=1, CARRYIN=1, CARRYINSEL=000, clock two cycles, assert rst asynchronously between edges.
  - Required: CIN drops to 0 before the next edge; CARRYINSEL_Q=000.
- Latency:
  - Stimulus: CARRYINREG=1, CECARRYIN=1, CARRYIN 0→1 before edge 3.
  - Required: CIN=1 after edge 3, not before.
  - Stimulus: repeat with CARRYINREG=0.
  - Required: CIN=1 combinationally.
- Select sweep:
  - Stimulus: CARRYINSELREG=0, PCIN[47]=1, P[47]=0, CARRYCASCIN=1, CARRYCASCOUT=0, rnd term=1, carryin_q=0; step sel 000..111.
  - Required CIN sequence: 0,0,1,1,0,1,1,0.
- Shift:
  - Stimulus: PCIN = 48'h8000_0002_0000.
  - Required: PCIN_SHR17 = 48'hFFFF_C000_0001.
  - Stimulus: PCIN = 48'h0000_0002_0000.
  - Required: PCIN_SHR17 = 48'h0000_0000_0001.
- Clock enable hold:
  - Stimulus: MREG=1, CEM=1 with A24=0, B17=0 at edge 1; then CEM=0, A24=1 at edge 2; sel=110.
  - Required: CIN=1 after both edges; rnd_q is not updated while CEM=0.
- Mixed registering:
  - Stimulus: CARRYINSELREG=1, CECTRL=1, sel 000→010 before edge 5, CARRYCASCIN=1, carryin_q=0.
  - Required: CIN=0 until edge 5, then 1.
